// File: rtl/video_frame_read_pkg.sv
// rtl/video_frame_read_pkg.sv - shared video read-path FSM states and default sizing
package video_frame_read_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    CHECK,
    REQ,
    BURST,
    END
  } vfr_state_t;

  localparam int VIDEO_BURST_LEN  = 64;
  localparam int VIDEO_FIFO_DEPTH = 256;
  localparam int PIXELS_PER_WORD  = 4;
  localparam int BURST_LEN_W      = 10;

endpackage

// File: rtl/video_frame_read_sync_fifo.sv
// rtl/video_frame_read_sync_fifo.sv - single-clock word FIFO with level output and flush
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign do_wr   = wr_en && (level != (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // rd_data is the word at the read pointer; rd_en retires it
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !rst && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/video_frame_read.sv
// rtl/video_frame_read.sv - frame reader: bursts memory words into a FIFO and unpacks 4 pixels per word
module video_frame_read
  import video_frame_read_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 25,
  parameter int BURST_LEN      = VIDEO_BURST_LEN,
  parameter int FIFO_DEPTH     = VIDEO_FIFO_DEPTH
) (
  input  logic                      video_clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     read_addr_0,
  input  logic [ADDR_WIDTH-1:0]     read_len,
  input  logic                      read_req,
  output logic                      read_req_ack,
  input  logic                      read_en,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      underflow,
  output logic                      rd_burst_req,
  output logic [BURST_LEN_W-1:0]    rd_burst_len,
  output logic [ADDR_WIDTH-1:0]     rd_burst_addr,
  input  logic                      rd_burst_data_valid,
  input  logic [MEM_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_finish
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  vfr_state_t                                    state;
  logic [ADDR_WIDTH-1:0]                         cur_addr;
  logic [ADDR_WIDTH-1:0]                         remaining;
  logic [1:0]                                    lane;
  logic [LEVEL_W-1:0]                            fifo_level;
  logic [LEVEL_W-1:0]                            fifo_free;
  logic                                          fifo_empty;
  logic                                          fifo_flush;
  logic                                          fifo_wr;
  logic                                          fifo_rd;
  logic [MEM_DATA_WIDTH-1:0]                     fifo_word;
  logic [PIXELS_PER_WORD-1:0][DATA_WIDTH-1:0]    word_lanes;
  logic [BURST_LEN_W-1:0]                        burst_len_next;
  logic [ADDR_WIDTH-1:0]                         burst_len_ext;

  assign fifo_free      = LEVEL_W'(FIFO_DEPTH) - fifo_level;
  assign fifo_flush     = (state == ACK);
  // Data is accepted only while a burst is outstanding, so beats that trail a reset are dropped
  assign fifo_wr        = rd_burst_data_valid && (state == REQ || state == BURST);
  assign fifo_rd        = read_en && !fifo_empty && (lane == 2'd3) && !fifo_flush;
  assign word_lanes     = fifo_word;
  assign burst_len_next = (remaining > ADDR_WIDTH'(BURST_LEN)) ? BURST_LEN_W'(BURST_LEN)
                                                              : remaining[BURST_LEN_W-1:0];
  assign burst_len_ext  = ADDR_WIDTH'(rd_burst_len);

  sync_fifo #(
    .WIDTH (MEM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (video_clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (rd_burst_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_word),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge video_clk) begin
    if (rst) begin
      state         <= IDLE;
      read_req_ack  <= 1'b0;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
    end else begin
      read_req_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (read_req) begin
            state        <= ACK;
            read_req_ack <= 1'b1;
          end
        end
        ACK: begin
          cur_addr  <= read_addr_0;
          remaining <= read_len;
          state     <= CHECK;
        end
        // A new request is only honoured here, so an in-flight burst always drains first
        CHECK: begin
          if (read_req) begin
            state        <= ACK;
            read_req_ack <= 1'b1;
          end else if (remaining == '0) begin
            state <= IDLE;
          end else if (fifo_free >= LEVEL_W'(BURST_LEN)) begin
            state         <= REQ;
            rd_burst_req  <= 1'b1;
            rd_burst_addr <= cur_addr;
            rd_burst_len  <= burst_len_next;
          end
        end
        REQ: state <= BURST;
        BURST: begin
          if (rd_burst_finish) begin
            state        <= END;
            rd_burst_req <= 1'b0;
          end
        end
        END: begin
          cur_addr  <= cur_addr + burst_len_ext;
          remaining <= remaining - burst_len_ext;
          state     <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush wins over a coincident pop: output clears and no underflow is reported
  always_ff @(posedge video_clk) begin
    if (rst || fifo_flush) begin
      lane      <= 2'd0;
      read_data <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (read_en) begin
        if (!fifo_empty) begin
          read_data <= word_lanes[lane];
          lane      <= lane + 2'd1;
        end else begin
          read_data <= '0;
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_frame_read.sv
// tb/tb_video_frame_read.sv - directed bench for video_frame_read with a simple burst memory model
module tb_video_frame_read;
  import video_frame_read_pkg::*;

  localparam int DW = 16;
  localparam int MW = 64;
  localparam int AW = 25;
  localparam int BL = 64;
  localparam int FD = 256;

  logic          video_clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_addr_0;
  logic [AW-1:0] read_len;
  logic          read_req;
  logic          read_req_ack;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          underflow;
  logic          rd_burst_req;
  logic [9:0]    rd_burst_len;
  logic [AW-1:0] rd_burst_addr;
  logic          rd_burst_data_valid;
  logic [MW-1:0] rd_burst_data;
  logic          rd_burst_finish;

  logic          m_valid = 1'b0;
  logic [MW-1:0] m_data = '0;
  logic          m_finish = 1'b0;
  logic          man_valid = 1'b0;
  logic [MW-1:0] man_data = '0;
  logic          man_finish = 1'b0;

  bit            mem_en = 1'b0;
  int            mem_gap = 1;
  int            trunc_idx = -1;
  int            trunc_beats = 0;
  bit            fixed_en = 1'b0;
  logic [MW-1:0] fixed_word = '0;

  logic [AW-1:0] burst_addr_q[$];
  int            burst_len_q[$];
  logic [AW-1:0] b_addr;
  int            beats;
  int            ack_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 video_clk = ~video_clk;

  assign rd_burst_data_valid = m_valid | man_valid;
  assign rd_burst_data       = man_valid ? man_data : m_data;
  assign rd_burst_finish     = m_finish | man_finish;

  video_frame_read #(
    .DATA_WIDTH     (DW),
    .MEM_DATA_WIDTH (MW),
    .ADDR_WIDTH     (AW),
    .BURST_LEN      (BL),
    .FIFO_DEPTH     (FD)
  ) dut (
    .video_clk           (video_clk),
    .rst                 (rst),
    .read_addr_0         (read_addr_0),
    .read_len            (read_len),
    .read_req            (read_req),
    .read_req_ack        (read_req_ack),
    .read_en             (read_en),
    .read_data           (read_data),
    .underflow           (underflow),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish)
  );

  function automatic logic [MW-1:0] word_at(input logic [AW-1:0] a);
    logic [15:0] p;
    p = 16'({a, 2'b00});
    return {p + 16'd3, p + 16'd2, p + 16'd1, p};
  endfunction

  function automatic logic [63:0] q_addr(input int i);
    if (i < burst_addr_q.size()) return 64'(burst_addr_q[i]);
    return '1;
  endfunction

  function automatic logic [63:0] q_len(input int i);
    if (i < burst_len_q.size()) return 64'(burst_len_q[i]);
    return '1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: answers each burst request after mem_gap cycles with incrementing words
  always begin : mem_model
    @(posedge video_clk);
    #1;
    if (mem_en && rd_burst_req === 1'b1 && rst === 1'b0) begin
      b_addr = rd_burst_addr;
      beats  = (int'(burst_addr_q.size()) == trunc_idx) ? trunc_beats : int'(rd_burst_len);
      burst_addr_q.push_back(rd_burst_addr);
      burst_len_q.push_back(int'(rd_burst_len));
      for (int g = 0; g < mem_gap; g++) begin
        @(posedge video_clk);
        #1;
      end
      for (int i = 0; i < beats; i++) begin
        if (rst === 1'b1) break;
        m_valid  = 1'b1;
        m_data   = fixed_en ? fixed_word : word_at(b_addr + AW'(i));
        m_finish = (i == beats - 1);
        @(posedge video_clk);
        #1;
      end
      m_valid  = 1'b0;
      m_finish = 1'b0;
    end
  end

  always @(negedge video_clk) begin
    if (read_req_ack === 1'b1) ack_cnt++;
  end

  always @(posedge video_clk) begin
    if (rst === 1'b0)
      assert (!(dut.fifo_wr && dut.fifo_level == 9'(FD))) else $error("fifo overflow write");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_request(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int n;
    n = 0;
    read_addr_0 = addr;
    read_len    = len;
    read_req    = 1'b1;
    do begin
      @(negedge video_clk);
      n++;
    end while (read_req_ack !== 1'b1 && n < 20);
    check("req_ack", read_req_ack, 1'b1);
    read_req = 1'b0;
  endtask

  task automatic wait_state(input vfr_state_t s, input int budget, input string tag);
    int n;
    n = 0;
    while (dut.state !== s && n < budget) begin
      @(negedge video_clk);
      n++;
    end
    check(tag, dut.state, s);
  endtask

  task automatic wait_bursts(input int cnt, input int budget, input string tag);
    int n;
    n = 0;
    while (burst_addr_q.size() < cnt && n < budget) begin
      @(negedge video_clk);
      n++;
    end
    check(tag, burst_addr_q.size(), cnt);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    read_en = 1'b1;
    @(negedge video_clk);
    read_en = 1'b0;
    check(tag, read_data, exp);
  endtask

  initial begin
    int a0;
    int n;
    bit fin;

    rst         = 1'b1;
    read_req    = 1'b0;
    read_en     = 1'b0;
    read_addr_0 = '0;
    read_len    = '0;
    repeat (3) @(negedge video_clk);
    check("rst_ack", read_req_ack, 1'b0);
    check("rst_breq", rd_burst_req, 1'b0);
    check("rst_uf", underflow, 1'b0);
    check("rst_blen", rd_burst_len, 10'd0);
    check("rst_baddr", rd_burst_addr, 25'd0);
    check("rst_rdata", read_data, 16'd0);
    check("rst_state", dut.state, IDLE);
    rst = 1'b0;

    // two full bursts, then pixel stream across a word boundary
    mem_en  = 1'b1;
    mem_gap = 1;
    a0      = ack_cnt;
    do_request(25'h100, 25'd128);
    wait_bursts(2, 600, "t1_bursts");
    wait_state(IDLE, 200, "t1_idle");
    repeat (5) @(negedge video_clk);
    check("t1_ack_pulses", 64'(ack_cnt - a0), 64'd1);
    check("t1_b0_addr", q_addr(0), 64'h100);
    check("t1_b0_len", q_len(0), 64'd64);
    check("t1_b1_addr", q_addr(1), 64'h140);
    check("t1_b1_len", q_len(1), 64'd64);
    for (int k = 0; k < 5; k++) pop_check("t1_pix", 16'(32'h400 + k));

    // short final burst
    burst_addr_q.delete();
    burst_len_q.delete();
    do_request(25'h100, 25'd100);
    wait_bursts(2, 600, "t2_bursts");
    wait_state(IDLE, 200, "t2_idle");
    check("t2_b0_addr", q_addr(0), 64'h100);
    check("t2_b0_len", q_len(0), 64'd64);
    check("t2_b1_addr", q_addr(1), 64'h140);
    check("t2_b1_len", q_len(1), 64'd36);
    check("t2_final_addr", dut.cur_addr, 25'h164);
    check("t2_remaining", dut.remaining, 25'd0);
    check("t2_breq_low", rd_burst_req, 1'b0);

    // 200 words buffered with work left: hold in CHECK until 8 words are drained
    burst_addr_q.delete();
    burst_len_q.delete();
    trunc_idx   = 3;
    trunc_beats = 8;
    do_request(25'h200, 25'd264);
    wait_bursts(4, 800, "t3_bursts");
    repeat (40) @(negedge video_clk);
    check("t3_hold_bursts", burst_addr_q.size(), 4);
    check("t3_hold_state", dut.state, CHECK);
    check("t3_level", dut.fifo_level, 9'd200);
    check("t3_breq_low", rd_burst_req, 1'b0);
    check("t3_b3_addr", q_addr(3), 64'h2C0);
    for (int k = 0; k < 31; k++) pop_check("t3_pix", 16'(32'h800 + k));
    check("t3_no_req_31", burst_addr_q.size(), 4);
    check("t3_state_31", dut.state, CHECK);
    pop_check("t3_pix32", 16'h81F);
    trunc_idx = -1;
    wait_bursts(5, 20, "t3_req_after_32");
    check("t3_b4_addr", q_addr(4), 64'h300);
    check("t3_b4_len", q_len(4), 64'd8);
    wait_state(IDLE, 200, "t3_idle");

    // lane order, hold, and underflow on an empty FIFO
    burst_addr_q.delete();
    burst_len_q.delete();
    fixed_en   = 1'b1;
    fixed_word = 64'h0004_0003_0002_0001;
    do_request(25'h0, 25'd1);
    wait_state(IDLE, 100, "t4_idle");
    fixed_en = 1'b0;
    check("t4_len", q_len(0), 64'd1);
    for (int k = 0; k < 4; k++) begin
      read_en = 1'b1;
      @(negedge video_clk);
      check("t4_lane", read_data, 16'(k + 1));
    end
    read_en = 1'b0;
    @(negedge video_clk);
    check("t4_hold", read_data, 16'd4);
    read_en = 1'b1;
    @(negedge video_clk);
    read_en = 1'b0;
    check("t4_uf_pulse", underflow, 1'b1);
    check("t4_uf_data", read_data, 16'd0);
    @(negedge video_clk);
    check("t4_uf_single", underflow, 1'b0);
    check("t4_lane_kept", dut.lane, 2'd0);

    // request during BURST waits for finish; flush beats a coincident pop; zero-length frame
    burst_addr_q.delete();
    burst_len_q.delete();
    mem_gap = 5;
    do_request(25'h400, 25'd64);
    wait_state(BURST, 20, "t5_burst");
    read_addr_0 = 25'h500;
    read_len    = 25'd0;
    read_req    = 1'b1;
    fin         = 1'b0;
    n           = 0;
    while (n < 300) begin
      @(negedge video_clk);
      n++;
      if (rd_burst_finish === 1'b1) fin = 1'b1;
      if (read_req_ack === 1'b1) break;
    end
    check("t5_ack_seen", read_req_ack, 1'b1);
    check("t5_ack_after_finish", fin, 1'b1);
    read_req = 1'b0;
    read_en  = 1'b1;
    @(negedge video_clk);
    check("t5_flush_data", read_data, 16'd0);
    check("t5_flush_no_uf", underflow, 1'b0);
    @(negedge video_clk);
    read_en = 1'b0;
    check("t5_empty_uf", underflow, 1'b1);
    wait_state(IDLE, 20, "t5_idle");
    check("t5_no_new_burst", burst_addr_q.size(), 1);
    check("t5_addr_latched", dut.cur_addr, 25'h500);

    // reset in the middle of a burst
    burst_addr_q.delete();
    burst_len_q.delete();
    mem_gap = 2;
    do_request(25'h600, 25'd64);
    wait_state(BURST, 20, "t6_burst");
    repeat (6) @(negedge video_clk);
    pop_check("t6_pix", 16'h1800);
    rst = 1'b1;
    @(negedge video_clk);
    check("t6_ack", read_req_ack, 1'b0);
    check("t6_breq", rd_burst_req, 1'b0);
    check("t6_uf", underflow, 1'b0);
    check("t6_blen", rd_burst_len, 10'd0);
    check("t6_baddr", rd_burst_addr, 25'd0);
    check("t6_rdata", read_data, 16'd0);
    check("t6_state", dut.state, IDLE);
    check("t6_level", dut.fifo_level, 9'd0);
    check("t6_lane", dut.lane, 2'd0);
    check("t6_cur_addr", dut.cur_addr, 25'd0);
    rst        = 1'b0;
    man_valid  = 1'b1;
    man_data   = 64'hDEAD_BEEF_0000_1111;
    man_finish = 1'b1;
    repeat (3) @(negedge video_clk);
    man_valid  = 1'b0;
    man_finish = 1'b0;
    @(negedge video_clk);
    check("t6_late_level", dut.fifo_level, 9'd0);
    check("t6_late_state", dut.state, IDLE);
    check("t6_late_breq", rd_burst_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
